parity_encoder: RTL and testbench

- Serial parity transmitter; the transmit end of the team's bit-serial parity link.
- Accepts a parallel word over a valid/ready handshake.
- Shifts the word out one bit per clock, LSB first, then appends one parity bit.
- Output stream (dataout) drives the serial parity decoder's datain directly; frames run back-to-back with no idle gap when data is available.

---
 rtl/parity_pkg.sv | 23 ++
 rtl/parity_encoder_if.sv | 46 ++++
 rtl/parity_encoder_piso_shift.sv | 37 +++
 rtl/parity_encoder.sv | 132 +++++++++++++
 tb/tb_parity_encoder.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the bit-serial parity link (encoder, decoder, benches).
package parity_pkg;

  // Default payload width per frame; a frame is DEFAULT_DATA_W + 1 clocks long.
  localparam int unsigned DEFAULT_DATA_W = 7;

  // Parity sense selectors for the PARITY_ODD parameter.
  localparam bit PARITY_SEL_EVEN = 1'b0;
  localparam bit PARITY_SEL_ODD  = 1'b1;

  // Encoder FSM state encoding, shared with the decoder so traces line up.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } enc_state_e;

  // Final parity bit: running XOR, flipped for odd sense, flipped again on injection.
  function automatic logic parity_out(input logic acc, input logic odd, input logic inv);
    return acc ^ odd ^ inv;
  endfunction

endpackage

// File: rtl/parity_encoder_if.sv
// Parallel-in / serial-out bus of the parity encoder.
// PARITY_ERR_INJECT_EN adds the inject_err request line.
interface parity_encoder_if
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
);

  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              dataout;
  logic              dout_valid;
  logic              sof;
  logic              par_bit;
`ifdef PARITY_ERR_INJECT_EN
  logic              inject_err;
`endif

`ifdef PARITY_ERR_INJECT_EN
  // Word source side.
  modport master (
    output din, din_valid, inject_err,
    input  din_ready, dataout, dout_valid, sof, par_bit
  );

  // Encoder side.
  modport slave (
    input  din, din_valid, inject_err,
    output din_ready, dataout, dout_valid, sof, par_bit
  );
`else
  // Word source side.
  modport master (
    output din, din_valid,
    input  din_ready, dataout, dout_valid, sof, par_bit
  );

  // Encoder side.
  modport slave (
    input  din, din_valid,
    output din_ready, dataout, dout_valid, sof, par_bit
  );
`endif

endinterface

// File: rtl/parity_encoder_piso_shift.sv
// Loadable LSB-first parallel-in serial-out register; ser_o is the current LSB.
module piso_shift #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         ser_o
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  // Load has priority over shift; zeros fill from the top.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = sr_q >> 1;
    end
  end

  // Shift register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign ser_o = sr_q[0];

endmodule

// File: rtl/parity_encoder.sv
// Serial parity transmitter: takes a word on a valid/ready handshake, sends it
// LSB first one bit per clock, then one parity bit. Frames run back-to-back.
// Optional: PARITY_ERR_INJECT_EN adds inject_err, which corrupts the frame's parity.
module parity_encoder
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter bit          PARITY_ODD = PARITY_SEL_EVEN
) (
  input  logic            clk,
  input  logic            rst,
  parity_encoder_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam int unsigned REM_W = DATA_W - 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  enc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             inj_q, inj_d;
  logic             dataout_q, dataout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             sof_q, sof_d;
  logic             par_bit_q, par_bit_d;

  logic             din_ready_c;
  logic             hs_c;
  logic             load_c;
  logic             shift_c;
  logic             inj_in_c;
  logic             ser_c;

`ifdef PARITY_ERR_INJECT_EN
  assign inj_in_c = bus.inject_err;
`else
  assign inj_in_c = 1'b0;
`endif

  // Bit 0 goes straight to dataout on load; the shifter holds bits 1..DATA_W-1.
  piso_shift #(
    .W (REM_W)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load_c),
    .shift_i (shift_c),
    .data_i  (bus.din[DATA_W-1:1]),
    .ser_o   (ser_c)
  );

  // Next-state, counter, accumulator and output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    inj_d        = inj_q;
    dataout_d    = 1'b0;
    dout_valid_d = 1'b0;
    sof_d        = 1'b0;
    par_bit_d    = 1'b0;
    load_c       = 1'b0;
    shift_c      = 1'b0;
    din_ready_c  = ~rst & ((state_q == ST_IDLE) | (state_q == ST_PARITY));
    hs_c         = bus.din_valid & din_ready_c;

    unique case (state_q)
      ST_IDLE, ST_PARITY: begin
        if (hs_c) begin
          // Fresh frame: counter and accumulator restart, bit 0 leads.
          state_d      = ST_SHIFT;
          load_c       = 1'b1;
          cnt_d        = '0;
          acc_d        = bus.din[0];
          inj_d        = inj_in_c;
          dataout_d    = bus.din[0];
          dout_valid_d = 1'b1;
          sof_d        = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        dout_valid_d = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d   = ST_PARITY;
          dataout_d = parity_out(acc_q, PARITY_ODD, inj_q);
          par_bit_d = 1'b1;
        end else begin
          shift_c   = 1'b1;
          dataout_d = ser_c;
          acc_d     = acc_q ^ ser_c;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      acc_q        <= 1'b0;
      inj_q        <= 1'b0;
      dataout_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      par_bit_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      inj_q        <= inj_d;
      dataout_q    <= dataout_d;
      dout_valid_q <= dout_valid_d;
      sof_q        <= sof_d;
      par_bit_q    <= par_bit_d;
    end
  end

  assign bus.din_ready  = din_ready_c;
  assign bus.dataout    = dataout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.sof        = sof_q;
  assign bus.par_bit    = par_bit_q;

endmodule

// File: tb/tb_parity_encoder.sv
// Bench for parity_encoder: even and odd instances share stimulus; a frame-level
// expected-bit queue and a receive-side decoder check every cycle.
module tb_parity_encoder;
  import parity_pkg::*;

  localparam int unsigned DW = 7;

  typedef struct {
    bit b;
    bit sof;
    bit par;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  parity_encoder_if #(.DATA_W(DW)) if_e ();
  parity_encoder_if #(.DATA_W(DW)) if_o ();

  parity_encoder #(.DATA_W(DW), .PARITY_ODD(PARITY_SEL_EVEN)) u_even (
    .clk (clk), .rst (rst), .bus (if_e)
  );
  parity_encoder #(.DATA_W(DW), .PARITY_ODD(PARITY_SEL_ODD)) u_odd (
    .clk (clk), .rst (rst), .bus (if_o)
  );

  exp_t           q_e[$];
  exp_t           q_o[$];
  logic [DW-1:0]  sent_q[$];
  bit             sinj_q[$];

  int unsigned    n_cmp = 0;
  int unsigned    n_err = 0;
  int             hs_cnt = 0;

  bit             v_drv;
  logic [DW-1:0]  din_drv;
  bit             inj_drv;

  logic [DW-1:0]  rx_word;
  int             rx_idx = 0;
  logic [15:0]    cap_e, cap_o;
  int             cap_n = 0;
  int             run_len = 0;
  int             max_run = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit inj);
    v_drv   = v;
    din_drv = d;
`ifdef PARITY_ERR_INJECT_EN
    inj_drv         = inj;
    if_e.inject_err = inj;
    if_o.inject_err = inj;
`else
    inj_drv = 1'b0;
`endif
    if_e.din_valid = v;
    if_o.din_valid = v;
    if_e.din       = d;
    if_o.din       = d;
  endtask

  // Expected frame: payload LSB first, then the parity bit for each sense.
  task automatic push_frame(input logic [DW-1:0] w, input bit inj);
    int  ones;
    bit  pe;
    ones = $countones(w);
    pe   = (ones % 2) == 1;
    for (int k = 0; k < int'(DW); k++) begin
      q_e.push_back('{b: w[k], sof: (k == 0), par: 1'b0});
      q_o.push_back('{b: w[k], sof: (k == 0), par: 1'b0});
    end
    q_e.push_back('{b: pe ^ inj,  sof: 1'b0, par: 1'b1});
    q_o.push_back('{b: !pe ^ inj, sof: 1'b0, par: 1'b1});
  endtask

  task automatic check_outputs();
    exp_t e;
    exp_t o;
    bit   err;
    e = (q_e.size() > 0) ? q_e[0] : '{b: 1'b0, sof: 1'b0, par: 1'b0};
    o = (q_o.size() > 0) ? q_o[0] : '{b: 1'b0, sof: 1'b0, par: 1'b0};
    chk("e_valid", 32'(if_e.dout_valid), 32'(q_e.size() > 0));
    chk("e_data",  32'(if_e.dataout),    32'(e.b));
    chk("e_sof",   32'(if_e.sof),        32'(e.sof));
    chk("e_par",   32'(if_e.par_bit),    32'(e.par));
    chk("e_ready", 32'(if_e.din_ready),  32'(!rst && q_e.size() <= 1));
    chk("o_valid", 32'(if_o.dout_valid), 32'(q_o.size() > 0));
    chk("o_data",  32'(if_o.dataout),    32'(o.b));
    chk("o_sof",   32'(if_o.sof),        32'(o.sof));
    chk("o_par",   32'(if_o.par_bit),    32'(o.par));
    chk("o_ready", 32'(if_o.din_ready),  32'(!rst && q_o.size() <= 1));

    if (if_e.dout_valid === 1'b1) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (cap_n < 16) begin
        cap_e[cap_n] = if_e.dataout;
        cap_o[cap_n] = if_o.dataout;
        cap_n++;
      end
      // Receive-side decoder on the even stream.
      if (if_e.sof === 1'b1) rx_idx = 0;
      if (if_e.par_bit !== 1'b1) begin
        if (rx_idx < int'(DW)) rx_word[rx_idx] = if_e.dataout;
        rx_idx++;
      end else if (sent_q.size() == 0) begin
        chk("dec_orphan_frame", 32'd1, 32'd0);
      end else begin
        err = ((^rx_word) ^ if_e.dataout) == 1'b1;
        chk("dec_data", 32'(rx_word), 32'(sent_q[0]));
        chk("dec_err",  32'(err),     32'(sinj_q[0]));
        sent_q.delete(0);
        sinj_q.delete(0);
      end
    end else begin
      run_len = 0;
    end
  endtask

  // One clock: update the reference at the edge, compare at the falling edge.
  task automatic tick();
    bit rdy;
    @(posedge clk);
    rdy = !rst && (q_e.size() <= 1);
    if (rst) begin
      q_e.delete();
      q_o.delete();
      sent_q.delete();
      sinj_q.delete();
    end else begin
      if (q_e.size() > 0) q_e.delete(0);
      if (q_o.size() > 0) q_o.delete(0);
      if (v_drv && rdy) begin
        push_frame(din_drv, inj_drv);
        sent_q.push_back(din_drv);
        sinj_q.push_back(inj_drv);
        hs_cnt++;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  // Hand one word over, then send the rest of its frame with din scrambled.
  task automatic send_word(input logic [DW-1:0] w);
    cap_n = 0;
    drive(1'b1, w, 1'b0);
    tick();
    for (int k = 0; k < int'(DW) + 2; k++) begin
      drive(1'b0, DW'($urandom), 1'b0);
      tick();
    end
  endtask

  initial begin
    int start;
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b0;
    tick();

    // Single frame, even and odd sense.
    send_word(7'b1011001);
    chk("t1_stream_even", 32'(cap_e[7:0]), 32'h59);
    chk("t1_stream_odd",  32'(cap_o[7:0]), 32'hD9);
    send_word(7'b0000111);
    chk("t2_stream_even", 32'(cap_e[7:0]), 32'h87);
    chk("t2_stream_odd",  32'(cap_o[7:0]), 32'h07);

    // Back-to-back frames with din_valid held high.
    max_run = 0;
    start   = hs_cnt;
    drive(1'b1, 7'h55, 1'b0);
    for (int k = 0; k < 40 && hs_cnt < start + 2; k++) begin
      tick();
      if (hs_cnt == start + 1) drive(1'b1, 7'h2A, 1'b0);
    end
    drive(1'b0, '0, 1'b0);
    chk("bb_handshakes", 32'(hs_cnt - start), 32'd2);
    for (int k = 0; k < 20; k++) tick();
    chk("bb_run_len", 32'(max_run), 32'd16);

    // Reset while bit 3 is on the line.
    drive(1'b1, 7'h6B, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_valid", 32'(if_e.dout_valid), 32'd0);
    chk("rst_mid_data",  32'(if_e.dataout),    32'd0);
    rst = 1'b0;
    tick();
    send_word(7'h3C);
    chk("post_rst_even", 32'(cap_e[7:0]), 32'h3C);
    chk("post_rst_odd",  32'(cap_o[7:0]), 32'hBC);

    // Random traffic: 100 words, din churning every cycle.
    start = hs_cnt;
    for (int k = 0; k < 3000 && hs_cnt < start + 100; k++) begin
      drive(($urandom % 3) != 0, DW'($urandom), ($urandom % 8) == 0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    chk("rnd_words", 32'(hs_cnt - start), 32'd100);
    for (int k = 0; k < 12; k++) tick();
    chk("rnd_drained", 32'(sent_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
